// File: rtl/instruction_decode_stage.sv
// One-entry registered decode stage between fetch and the controller/register file.
// Holds a 16-bit instruction under valid/ready and decodes fields from the held copy.
module instruction_decode_stage #(
  parameter int DATA_W         = 16,
  parameter int HOLD_ON_BADSEL = 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              flush,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [15:0]       instr,
  output logic              out_valid,
  input  logic              out_ready,
  input  logic [2:0]        nsel,
  output logic [2:0]        opcode,
  output logic [1:0]        op,
  output logic [1:0]        ALUop,
  output logic [1:0]        shift,
  output logic [DATA_W-1:0] sximm5,
  output logic [DATA_W-1:0] sximm8,
  output logic [2:0]        readnum,
  output logic [2:0]        writenum,
  output logic              nsel_err,
  output logic              state_dbg
);

  // Handshake: a transfer happens on a rising edge where in_valid & in_ready.
  // in_ready is combinational: the slot is free or being drained this cycle,
  // and no flush is pending. The producer holds instr while in_valid & ~in_ready.

  typedef enum logic {
    EMPTY = 1'b0,
    FULL  = 1'b1
  } state_t;

  state_t      state_q;
  state_t      state_d;
  logic        capture;
  logic [15:0] instr_q;
  logic [2:0]  last_num;
  logic [2:0]  sel_num;
  logic        sel_legal;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= EMPTY;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    in_ready  = ~flush & ((state_q == EMPTY) | out_ready);
    capture   = in_valid & in_ready;
    out_valid = (state_q == FULL);
    state_dbg = state_q;
    if (flush) begin
      state_d = EMPTY;
    end else if (capture) begin
      state_d = FULL;
    end else if ((state_q == FULL) && out_ready) begin
      state_d = EMPTY;
    end
  end

  // Held instruction survives flush; only a capture or reset changes it.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      instr_q <= 16'h0000;
    end else if (capture) begin
      instr_q <= instr;
    end
  end

  assign opcode = instr_q[15:13];
  assign op     = instr_q[12:11];
  assign ALUop  = instr_q[12:11];
  assign shift  = instr_q[4:3];
  assign sximm5 = {{(DATA_W-5){instr_q[4]}}, instr_q[4:0]};
  assign sximm8 = {{(DATA_W-8){instr_q[7]}}, instr_q[7:0]};

  always_comb begin
    sel_legal = 1'b1;
    sel_num   = 3'd0;
    case (nsel)
      3'b001:  sel_num = instr_q[2:0];
      3'b010:  sel_num = instr_q[7:5];
      3'b100:  sel_num = instr_q[10:8];
      default: sel_legal = 1'b0;
    endcase
  end

  // Explicit hold register replaces the latch the old combinational decoder implied.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      last_num <= 3'd0;
      nsel_err <= 1'b0;
    end else begin
      if (sel_legal) begin
        last_num <= sel_num;
      end
      nsel_err <= out_valid & ~sel_legal;
    end
  end

  always_comb begin
    if (sel_legal) begin
      readnum = sel_num;
    end else if (HOLD_ON_BADSEL != 0) begin
      readnum = last_num;
    end else begin
      readnum = 3'd0;
    end
    writenum = readnum;
  end

endmodule
